wave_recorder: RTL and testbench

- Capture side of the waveform path: writes incoming audio samples into the waveform RAM and reports the recorded length.
- The playback oscillator later reads that RAM back by index, wrapping at the reported length.
- Sits between the ADC/mic sample stream and the RAM write port.
- Provides threshold-triggered start, decimation and a hard depth limit.

---
 rtl/wave_recorder.sv | 172 +++++++++++++++++
 tb/tb_wave_recorder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_recorder.sv
// wave_recorder
// Capture side of the waveform path. Waits for a sample whose magnitude
// reaches a threshold and records from that sample on. It writes every
// (decim_in+1)th valid sample into the waveform RAM and stops on
// record_in low or when DEPTH samples have been stored. It then reports
// the recorded length for the playback oscillator.
//
// Ports:
//   clk_in           system clock
//   rst_in           synchronous active-high reset
//   record_in        level: high arms/records, low stops
//   sample_valid_in  one-cycle strobe, sample_data_in is new
//   sample_data_in   signed two's-complement sample
//   threshold_in     unsigned trigger magnitude
//   decim_in         valid samples skipped between stored samples
//   ram_addr_out     registered RAM write address
//   ram_data_out     registered RAM write data
//   ram_we_out       registered one-cycle RAM write enable
//   wave_width_out   length of the last completed recording
//   busy_out         high while ARMED or RECORD
//   done_out         one-cycle pulse when a recording completes
//
// Handshake: there is no back-pressure. Every cycle with sample_valid_in
// high offers a sample, and it is taken or ignored in that cycle. A
// sample that is stored shows up on the RAM port one cycle later, as a
// single ram_we_out pulse with its address and data. Address and data
// hold their values between pulses.
module wave_recorder #(
    parameter int WW_WIDTH     = 18,
    parameter int SAMPLE_WIDTH = 16,
    parameter int DEPTH        = 240000
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    record_in,
    input  logic                    sample_valid_in,
    input  logic [SAMPLE_WIDTH-1:0] sample_data_in,
    input  logic [SAMPLE_WIDTH-1:0] threshold_in,
    input  logic [7:0]              decim_in,
    output logic [WW_WIDTH-1:0]     ram_addr_out,
    output logic [SAMPLE_WIDTH-1:0] ram_data_out,
    output logic                    ram_we_out,
    output logic [WW_WIDTH-1:0]     wave_width_out,
    output logic                    busy_out,
    output logic                    done_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_RECORD = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [WW_WIDTH-1:0] DEPTH_W = WW_WIDTH'(DEPTH);

    state_t                    state_q, state_d;
    logic [WW_WIDTH-1:0]       count_q, count_d;
    logic [7:0]                decim_cnt_q, decim_cnt_d;
    logic [WW_WIDTH-1:0]       addr_q, addr_d;
    logic [SAMPLE_WIDTH-1:0]   data_q, data_d;
    logic                      we_q, we_d;
    logic [WW_WIDTH-1:0]       width_q, width_d;
    logic                      done_q, done_d;

    // Magnitude is one bit wider than the sample, so the most negative
    // sample gives the full 2**(SAMPLE_WIDTH-1).
    logic [SAMPLE_WIDTH:0]     sample_ext;
    logic [SAMPLE_WIDTH:0]     sample_mag;
    logic                      trigger;
    logic [WW_WIDTH-1:0]       count_inc;

    assign sample_ext = {sample_data_in[SAMPLE_WIDTH-1], sample_data_in};
    assign sample_mag = sample_data_in[SAMPLE_WIDTH-1] ? (~sample_ext + 1'b1) : sample_ext;
    assign trigger    = sample_valid_in && (sample_mag >= {1'b0, threshold_in});
    assign count_inc  = count_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        decim_cnt_d = decim_cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        we_d        = 1'b0;
        width_d     = width_q;
        done_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (record_in) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                // A stop wins over a trigger in the same cycle.
                if (!record_in) begin
                    state_d = ST_IDLE;
                end else if (trigger) begin
                    we_d        = 1'b1;
                    addr_d      = '0;
                    data_d      = sample_data_in;
                    count_d     = WW_WIDTH'(1);
                    decim_cnt_d = '0;
                    state_d     = ST_RECORD;
                    // A one-sample RAM is full after the trigger sample.
                    if (DEPTH_W == WW_WIDTH'(1)) begin
                        state_d = ST_DONE;
                        width_d = WW_WIDTH'(1);
                        done_d  = 1'b1;
                    end
                end
            end
            ST_RECORD: begin
                if (!record_in) begin
                    state_d = ST_DONE;
                    width_d = count_q;
                    done_d  = 1'b1;
                end else if (sample_valid_in) begin
                    // ">=" (not "==") keeps the skip count sane when
                    // decim_in drops below the running count.
                    if (decim_cnt_q >= decim_in) begin
                        we_d        = 1'b1;
                        addr_d      = count_q;
                        data_d      = sample_data_in;
                        count_d     = count_inc;
                        decim_cnt_d = '0;
                        if (count_inc == DEPTH_W) begin
                            state_d = ST_DONE;
                            width_d = count_inc;
                            done_d  = 1'b1;
                        end
                    end else begin
                        decim_cnt_d = decim_cnt_q + 8'd1;
                    end
                end
            end
            ST_DONE: begin
                // A held record_in never re-arms; it must drop first.
                if (!record_in) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            decim_cnt_q <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            we_q        <= 1'b0;
            width_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            decim_cnt_q <= decim_cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            we_q        <= we_d;
            width_q     <= width_d;
            done_q      <= done_d;
        end
    end

    assign ram_addr_out   = addr_q;
    assign ram_data_out   = data_q;
    assign ram_we_out     = we_q;
    assign wave_width_out = width_q;
    assign done_out       = done_q;
    assign busy_out       = (state_q == ST_ARMED) || (state_q == ST_RECORD);

endmodule

// File: tb/tb_wave_recorder.sv
// Directed and randomized checks of wave_recorder. The DUT is built with
// DEPTH = 8 so that the depth limit is reached within a short recording.
module tb_wave_recorder;

    localparam int WW    = 18;
    localparam int SW    = 16;
    localparam int DEPTH = 8;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          record_in;
    logic          sample_valid_in;
    logic [SW-1:0] sample_data_in;
    logic [SW-1:0] threshold_in;
    logic [7:0]    decim_in;
    logic [WW-1:0] ram_addr_out;
    logic [SW-1:0] ram_data_out;
    logic          ram_we_out;
    logic [WW-1:0] wave_width_out;
    logic          busy_out;
    logic          done_out;

    int checks   = 0;
    int failures = 0;

    // Write and done-pulse monitor.
    logic [WW-1:0] got_addr[$];
    logic [SW-1:0] got_data[$];
    int            done_cnt;
    int            prev_width;

    // Samples offered during one recording session.
    logic [SW-1:0] stim[$];

    wave_recorder #(.WW_WIDTH(WW), .SAMPLE_WIDTH(SW), .DEPTH(DEPTH)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .record_in(record_in),
        .sample_valid_in(sample_valid_in),
        .sample_data_in(sample_data_in),
        .threshold_in(threshold_in),
        .decim_in(decim_in),
        .ram_addr_out(ram_addr_out),
        .ram_data_out(ram_data_out),
        .ram_we_out(ram_we_out),
        .wave_width_out(wave_width_out),
        .busy_out(busy_out),
        .done_out(done_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        #1;
        if (ram_we_out) begin
            got_addr.push_back(ram_addr_out);
            got_data.push_back(ram_data_out);
        end
        if (done_out) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Inputs change on the falling edge; outputs read just after this
    // falling edge reflect the inputs driven one cycle earlier.
    task automatic cyc(input logic rec, input logic v, input logic [SW-1:0] d);
        @(negedge clk_in);
        record_in       = rec;
        sample_valid_in = v;
        sample_data_in  = d;
    endtask

    function automatic logic [SW-1:0] s16(input int v);
        logic [31:0] t;
        t = v;
        return t[SW-1:0];
    endfunction

    function automatic int mag(input logic [SW-1:0] s);
        int v;
        v = int'($signed(s));
        return (v < 0) ? -v : v;
    endfunction

    task automatic clear_mon();
        got_addr.delete();
        got_data.delete();
        done_cnt = 0;
    endtask

    task automatic compare_writes(input string tag, input logic [SW-1:0] exp_q[$],
                                  input int exp_width, input int exp_done);
        check({tag, ".n_writes"}, got_data.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
            check($sformatf("%s.addr%0d", tag, i), got_addr[i], i);
            check($sformatf("%s.data%0d", tag, i), got_data[i], exp_q[i]);
        end
        check({tag, ".done_pulses"}, done_cnt, exp_done);
        check({tag, ".width"}, wave_width_out, exp_width);
        check({tag, ".busy_idle"}, busy_out, 0);
    endtask

    // Reference: the first sample reaching the threshold is stored, then
    // every (dec+1)th valid sample after it, up to DEPTH samples.
    task automatic run_session(input string tag, input logic [SW-1:0] thr,
                               input logic [7:0] dec, input int gap_max);
        logic [SW-1:0] exp_q[$];
        int first;
        int exp_width;
        clear_mon();
        threshold_in = thr;
        decim_in     = dec;
        cyc(1, 0, '0);
        foreach (stim[i]) begin
            repeat ($urandom_range(gap_max, 0)) cyc(1, 0, '0);
            cyc(1, 1, stim[i]);
        end
        cyc(1, 0, '0);
        cyc(1, 0, '0);
        cyc(0, 0, '0);
        cyc(0, 0, '0);
        cyc(0, 0, '0);

        first = -1;
        foreach (stim[i]) begin
            if (first < 0) begin
                if (mag(stim[i]) >= int'(thr)) begin
                    first = i;
                    exp_q.push_back(stim[i]);
                end
            end else if (((i - first) % (int'(dec) + 1)) == 0 && exp_q.size() < DEPTH) begin
                exp_q.push_back(stim[i]);
            end
        end
        exp_width = (first >= 0) ? exp_q.size() : prev_width;
        compare_writes(tag, exp_q, exp_width, (first >= 0) ? 1 : 0);
        prev_width = exp_width;
    endtask

    initial begin
        logic [SW-1:0] exp_q[$];
        rst_in = 1'b1;
        record_in = 1'b0;
        sample_valid_in = 1'b0;
        sample_data_in = '0;
        threshold_in = '0;
        decim_in = '0;
        done_cnt = 0;
        prev_width = 0;
        repeat (3) @(negedge clk_in);
        check("rst.addr", ram_addr_out, 0);
        check("rst.data", ram_data_out, 0);
        check("rst.we", ram_we_out, 0);
        check("rst.width", wave_width_out, 0);
        check("rst.busy", busy_out, 0);
        check("rst.done", done_out, 0);
        rst_in = 1'b0;

        // Basic recording: 1..5, checked cycle by cycle.
        clear_mon();
        cyc(1, 0, '0);
        cyc(1, 0, '0);
        check("t1.busy_armed", busy_out, 1);
        for (int i = 1; i <= 5; i++) begin
            cyc(1, 1, s16(i));
            check($sformatf("t1.we_idle%0d", i), ram_we_out, 0);
            cyc(1, 0, '0);
            check($sformatf("t1.we%0d", i), ram_we_out, 1);
            check($sformatf("t1.addr%0d", i), ram_addr_out, i - 1);
            check($sformatf("t1.data%0d", i), ram_data_out, i);
        end
        cyc(0, 0, '0);
        cyc(0, 0, '0);
        check("t1.done_pulse", done_out, 1);
        check("t1.width_now", wave_width_out, 5);
        cyc(0, 0, '0);
        check("t1.done_once", done_out, 0);
        exp_q = '{s16(1), s16(2), s16(3), s16(4), s16(5)};
        compare_writes("t1", exp_q, 5, 1);
        prev_width = 5;

        // Threshold trigger.
        stim = '{s16(10), s16(-500), s16(-1200), s16(300)};
        run_session("thr", s16(1000), 8'd0, 0);

        // Decimation by 3.
        stim.delete();
        for (int i = 0; i < 10; i++) stim.push_back(s16(i));
        run_session("decim", '0, 8'd2, 1);

        // Most negative sample has magnitude 32768.
        stim = '{s16(32767), s16(-32768), s16(5)};
        run_session("mag", s16(32768), 8'd0, 0);

        // Depth limit with record held high through 20 samples.
        stim.delete();
        for (int i = 0; i < 20; i++) stim.push_back(s16(100 + i));
        run_session("depth", '0, 8'd0, 1);

        // Stop in the same cycle as a qualifying sample.
        clear_mon();
        threshold_in = '0;
        decim_in = '0;
        cyc(1, 0, '0);
        cyc(1, 1, s16(7));
        cyc(1, 1, s16(8));
        cyc(1, 1, s16(9));
        cyc(0, 1, s16(10));
        cyc(0, 0, '0);
        cyc(0, 0, '0);
        cyc(0, 0, '0);
        exp_q = '{s16(7), s16(8), s16(9)};
        compare_writes("stopwin", exp_q, 3, 1);
        prev_width = 3;

        // Stop while armed: nothing written, no done, width kept.
        clear_mon();
        threshold_in = s16(16'hFFFF);
        cyc(1, 0, '0);
        cyc(1, 1, s16(5));
        cyc(0, 1, s16(-32768));
        cyc(0, 0, '0);
        cyc(0, 0, '0);
        exp_q.delete();
        compare_writes("armstop", exp_q, 3, 0);

        // Reset in the middle of a recording.
        clear_mon();
        threshold_in = '0;
        cyc(1, 0, '0);
        cyc(1, 1, s16(1));
        cyc(1, 1, s16(2));
        cyc(1, 1, s16(3));
        cyc(1, 0, '0);
        check("midrst.we3", ram_we_out, 1);
        rst_in = 1'b1;
        cyc(1, 0, '0);
        check("midrst.addr", ram_addr_out, 0);
        check("midrst.data", ram_data_out, 0);
        check("midrst.we", ram_we_out, 0);
        check("midrst.width", wave_width_out, 0);
        check("midrst.busy", busy_out, 0);
        check("midrst.done", done_out, 0);
        rst_in = 1'b0;
        cyc(0, 0, '0);
        prev_width = 0;

        // Randomized sessions against the reference model.
        for (int r = 0; r < 8; r++) begin
            logic [SW-1:0] thr;
            stim.delete();
            repeat ($urandom_range(14, 3)) stim.push_back(SW'($urandom));
            thr = (r % 3 == 0) ? '0 : SW'($urandom_range(40000, 0));
            run_session($sformatf("rand%0d", r), thr, 8'($urandom_range(3, 0)), 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
